// File: rtl/flash_resp.sv
// Parallel NOR flash responder: decodes AMD-style unlock/command write cycles,
// serves array/autoselect/status reads and runs embedded program/erase on a byte store.
module flash_resp #(
   parameter logic [7:0]  MFR_ID      = 8'h01,
   parameter logic [7:0]  DEV_ID      = 8'hA4,
   parameter int unsigned PROG_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [18:0] rom_a,
   inout  wire  [7:0]  rom_d,
   input  logic        rom_cs_n,
   input  logic        rom_oe_n,
   input  logic        rom_we_n,
   output logic [18:0] mem_a,
   output logic [7:0]  mem_wd,
   output logic        mem_we,
   input  logic [7:0]  mem_rd,
   output logic        busy
);

   localparam int CW = $clog2(PROG_CYCLES + 2);
   localparam logic [CW-1:0] PROG_LAST = CW'(PROG_CYCLES + 1);

   typedef enum logic [3:0] {
      READ, UNL1, UNL2, PGM, ER1, ER2, ER3, ERSEL, AUTOSEL, PROG, ERASE
   } stateT;

   stateT          state_q, state_d;
   logic           csn_q, oen_q, wen_q, oenPrev_q, wrAct_q;
   logic [18:0]    aReg_q, cmdA_q;
   logic [7:0]     cmdD_q;
   logic [18:0]    workA_q, workA_d;
   logic [7:0]     workD_q, workD_d;
   logic           chip_q, chip_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           dq6_q;

   logic           wrActive, commit, readDone, isBusy;
   logic           hit555, hit2AA;
   logic [7:0]     rdData;

   assign wrActive = ~csn_q & ~wen_q;
   assign commit   = wrAct_q & ~wrActive;
   assign readDone = oen_q & ~oenPrev_q & ~csn_q;
   assign isBusy   = (state_q == PROG) || (state_q == ERASE);
   assign hit555   = (cmdA_q[10:0] == 11'h555);
   assign hit2AA   = (cmdA_q[10:0] == 11'h2AA);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= READ;
         csn_q     <= 1'b1;
         oen_q     <= 1'b1;
         wen_q     <= 1'b1;
         oenPrev_q <= 1'b1;
         wrAct_q   <= 1'b0;
         aReg_q    <= '0;
         cmdA_q    <= '0;
         cmdD_q    <= '0;
         workA_q   <= '0;
         workD_q   <= '0;
         chip_q    <= 1'b0;
         cnt_q     <= '0;
         dq6_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         csn_q     <= rom_cs_n;
         oen_q     <= rom_oe_n;
         wen_q     <= rom_we_n;
         oenPrev_q <= oen_q;
         wrAct_q   <= wrActive;
         aReg_q    <= rom_a;
         workA_q   <= workA_d;
         workD_q   <= workD_d;
         chip_q    <= chip_d;
         cnt_q     <= cnt_d;
         if (wrActive) begin
            cmdA_q <= rom_a;
            cmdD_q <= rom_d;
         end
         // DQ6 idles at 0 so every busy period starts toggling from 0
         if (!isBusy)
            dq6_q <= 1'b0;
         else if (readDone)
            dq6_q <= ~dq6_q;
      end
   end

   always_comb begin
      state_d = state_q;
      workA_d = workA_q;
      workD_d = workD_q;
      chip_d  = chip_q;
      cnt_d   = cnt_q;
      case (state_q)
         READ, AUTOSEL: begin
            if (commit) begin
               if (cmdD_q == 8'hAA && hit555)
                  state_d = UNL1;
               else if (cmdD_q == 8'hF0)
                  state_d = READ;
            end
         end
         UNL1: if (commit) state_d = (cmdD_q == 8'h55 && hit2AA) ? UNL2 : READ;
         UNL2: begin
            if (commit) begin
               if (hit555 && cmdD_q == 8'hA0)
                  state_d = PGM;
               else if (hit555 && cmdD_q == 8'h80)
                  state_d = ER1;
               else if (hit555 && cmdD_q == 8'h90)
                  state_d = AUTOSEL;
               else
                  state_d = READ;
            end
         end
         ER1: if (commit) state_d = (cmdD_q == 8'hAA && hit555) ? ER2 : READ;
         ER2: if (commit) state_d = (cmdD_q == 8'h55 && hit2AA) ? ERSEL : READ;
         ERSEL: begin
            if (commit) begin
               if (cmdD_q == 8'h30) begin
                  state_d = ERASE;
                  workA_d = {cmdA_q[18:16], 16'h0000};
                  chip_d  = 1'b0;
               end else if (cmdD_q == 8'h10 && hit555) begin
                  state_d = ERASE;
                  workA_d = '0;
                  chip_d  = 1'b1;
               end else begin
                  state_d = READ;
               end
            end
         end
         PGM: begin
            if (commit) begin
               state_d = PROG;
               workA_d = cmdA_q;
               workD_d = cmdD_q;
               cnt_d   = '0;
            end
         end
         // cnt 0 fetches the old byte, cnt 1 writes it back, then PROG_CYCLES idle clocks
         PROG: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == PROG_LAST)
               state_d = READ;
         end
         ERASE: begin
            workA_d = workA_q + 19'd1;
            if (chip_q ? (&workA_q) : (&workA_q[15:0]))
               state_d = READ;
         end
         default: state_d = READ;
      endcase
   end

   always_comb begin
      mem_a  = aReg_q;
      mem_we = 1'b0;
      mem_wd = 8'hFF;
      busy   = 1'b0;
      rdData = mem_rd;
      case (state_q)
         PROG: begin
            mem_a  = workA_q;
            busy   = 1'b1;
            rdData = {~workD_q[7], dq6_q, 6'b0};
            if (cnt_q == CW'(1)) begin
               mem_we = 1'b1;
               mem_wd = mem_rd & workD_q;
            end
         end
         ERASE: begin
            mem_a  = workA_q;
            busy   = 1'b1;
            mem_we = 1'b1;
            rdData = {1'b0, dq6_q, 6'b0};
         end
         AUTOSEL: begin
            case (aReg_q[1:0])
               2'd0:    rdData = MFR_ID;
               2'd1:    rdData = DEV_ID;
               default: rdData = 8'h00;
            endcase
         end
         default: ;
      endcase
   end

   assign rom_d = (!rom_cs_n && !rom_oe_n && rom_we_n) ? rdData : 8'hzz;

endmodule

// File: tb/tb_flash_resp.sv
// Randomized bench for flash_resp: drives bus cycles and checks against a byte-array reference model.
module tb_flash_resp;

   localparam int TB_PROG = 48;
   localparam int MEMSZ   = 524288;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [18:0] rom_a;
   logic        rom_cs_n, rom_oe_n, rom_we_n;
   wire  [7:0]  rom_d;
   logic [7:0]  tbData;
   logic        tbDrive;
   logic [18:0] mem_a;
   logic [7:0]  mem_wd, mem_rd;
   logic        mem_we, busy;

   logic [7:0]  mem    [0:MEMSZ-1];
   logic [7:0]  refMem [0:MEMSZ-1];
   logic        preload;
   int          weCount = 0;
   int          ascErr  = 0;
   int          busyClk = 0;
   logic        weDly   = 1'b0;
   logic [18:0] lastWeA = '0;
   logic [18:0] firstWeA = '0;
   int          tests = 0;
   int          failed = 0;

   assign rom_d = tbDrive ? tbData : 8'hzz;

   always #5 clk = ~clk;

   flash_resp #(.MFR_ID(8'h01), .DEV_ID(8'hA4), .PROG_CYCLES(TB_PROG)) dut (
      .clk(clk), .rst_n(rst_n), .rom_a(rom_a), .rom_d(rom_d),
      .rom_cs_n(rom_cs_n), .rom_oe_n(rom_oe_n), .rom_we_n(rom_we_n),
      .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd), .busy(busy)
   );

   // Backing store with one-clock read latency plus write-burst bookkeeping
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < MEMSZ; i++) mem[i] <= refMem[i];
      end else if (mem_we) begin
         mem[mem_a] <= mem_wd;
         weCount    <= weCount + 1;
         lastWeA    <= mem_a;
         if (weDly && mem_a != lastWeA + 19'd1) ascErr <= ascErr + 1;
         if (!weDly) firstWeA <= mem_a;
      end
      weDly  <= mem_we;
      mem_rd <= mem[mem_a];
   end

   always @(negedge clk) if (busy) busyClk <= busyClk + 1;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] rndHi();
      return 8'($urandom_range(0, 255));
   endfunction

   task automatic applyStimulus(input logic [18:0] addr, input logic [7:0] data);
      @(negedge clk);
      rom_a = addr; tbData = data; tbDrive = 1'b1;
      rom_oe_n = 1'b1; rom_cs_n = 1'b0; rom_we_n = 1'b0;
      repeat (2) @(negedge clk);
      rom_we_n = 1'b1; rom_cs_n = 1'b1;
      @(negedge clk);
      tbDrive = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic busRead(input logic [18:0] addr, output logic [7:0] data);
      @(negedge clk);
      rom_a = addr; rom_we_n = 1'b1; rom_cs_n = 1'b0; rom_oe_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      data = rom_d;
      rom_oe_n = 1'b1;
      repeat (2) @(negedge clk);
      rom_cs_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic unlock();
      applyStimulus({rndHi(), 11'h555}, 8'hAA);
      applyStimulus({rndHi(), 11'h2AA}, 8'h55);
   endtask

   task automatic waitIdle(input int limit, input string tag);
      int n = 0;
      while (busy && n < limit) begin
         @(negedge clk);
         n++;
      end
      checkOutput(tag, 32'(busy), 32'd0);
   endtask

   task automatic imageCheck(input string tag);
      int n = 0;
      for (int i = 0; i < MEMSZ; i++) if (mem[i] !== refMem[i]) n++;
      checkOutput(tag, 32'(n), 32'd0);
   endtask

   task automatic doProgram(input logic [18:0] addr, input logic [7:0] data, input bit readStatus);
      logic [7:0] st;
      int b0;
      unlock();
      applyStimulus({rndHi(), 11'h555}, 8'hA0);
      b0 = busyClk;
      applyStimulus(addr, data);
      checkOutput("prog busy", 32'(busy), 32'd1);
      if (readStatus) begin
         busRead(addr, st);
         checkOutput("prog status", 32'(st), 32'({~data[7], 7'b0}));
      end
      refMem[addr] = refMem[addr] & data;
      waitIdle(500, "prog done");
      if (!readStatus) begin
         int d = busyClk - b0;
         checkOutput("prog busy length", 32'(d >= TB_PROG + 1 && d <= TB_PROG + 3), 32'd1);
      end
   endtask

   initial begin
      logic [7:0]  rd;
      logic [18:0] addr;
      logic [7:0]  data;
      logic [2:0]  sec;
      logic [18:0] base;
      int w0, a0, n, nbad;

      rst_n = 1'b0; rom_cs_n = 1'b1; rom_oe_n = 1'b1; rom_we_n = 1'b1;
      rom_a = '0; tbData = '0; tbDrive = 1'b0; preload = 1'b0;
      for (int i = 0; i < MEMSZ; i++) refMem[i] = 8'($urandom_range(0, 255));
      refMem[19'h12345] = 8'h5A;
      @(negedge clk); preload = 1'b1;
      @(negedge clk); preload = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset mem_we", 32'(mem_we), 32'd0);
      checkOutput("reset mem_a", 32'(mem_a), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Plain array reads
      w0 = weCount;
      busRead(19'h12345, rd);
      checkOutput("read 12345", 32'(rd), 32'h5A);
      for (int i = 0; i < 12; i++) begin
         addr = 19'($urandom_range(0, MEMSZ - 1));
         busRead(addr, rd);
         checkOutput("random read", 32'(rd), 32'(refMem[addr]));
      end
      checkOutput("reads no mem_we", 32'(weCount - w0), 32'd0);

      // Program 0Fh over 5Ah with DQ6 toggle observation and an ignored F0h
      unlock();
      applyStimulus({rndHi(), 11'h555}, 8'hA0);
      applyStimulus(19'h12345, 8'h0F);
      checkOutput("prog0 busy", 32'(busy), 32'd1);
      busRead(19'h12345, rd);
      checkOutput("status read 1", 32'(rd), 32'h80);
      busRead(19'h12345, rd);
      checkOutput("status read 2", 32'(rd), 32'hC0);
      busRead(19'h00000, rd);
      checkOutput("status read 3", 32'(rd), 32'h80);
      applyStimulus(19'h00000, 8'hF0);
      checkOutput("F0 while busy", 32'(busy), 32'd1);
      refMem[19'h12345] = refMem[19'h12345] & 8'h0F;
      waitIdle(500, "prog0 done");
      busRead(19'h12345, rd);
      checkOutput("read after prog", 32'(rd), 32'h0A);

      // Random programs, first one timed without status reads
      for (int i = 0; i < 6; i++) begin
         addr = 19'($urandom_range(0, MEMSZ - 1));
         data = 8'($urandom_range(0, 255));
         doProgram(addr, data, i != 0);
         busRead(addr, rd);
         checkOutput("prog readback", 32'(rd), 32'(refMem[addr]));
      end

      // Autoselect, program launched from autoselect, exit with F0h
      unlock();
      applyStimulus({rndHi(), 11'h555}, 8'h90);
      for (int k = 0; k < 4; k++) begin
         busRead({17'($urandom_range(0, 131071)), 2'(k)}, rd);
         checkOutput("autoselect", 32'(rd), (k == 0) ? 32'h01 : (k == 1) ? 32'hA4 : 32'h00);
      end
      applyStimulus(19'h00000, 8'hF0);
      busRead(19'h00000, rd);
      checkOutput("array after F0", 32'(rd), 32'(refMem[0]));
      unlock();
      applyStimulus({rndHi(), 11'h555}, 8'h90);
      addr = 19'($urandom_range(0, MEMSZ - 1));
      data = 8'($urandom_range(0, 255));
      doProgram(addr, data, 1'b1);
      busRead(addr, rd);
      checkOutput("prog from autosel", 32'(rd), 32'(refMem[addr]));

      // Broken unlock, then junk writes: nothing may reach the store
      w0 = weCount;
      applyStimulus(19'h00555, 8'hAA);
      applyStimulus(19'h002AA, 8'h56);
      applyStimulus(19'h00555, 8'hA0);
      applyStimulus(19'h12345, 8'h00);
      for (int i = 0; i < 8; i++) begin
         data = 8'($urandom_range(0, 255));
         if (data == 8'hAA) data = 8'h11;
         applyStimulus(19'($urandom_range(0, MEMSZ - 1)), data);
      end
      checkOutput("junk busy", 32'(busy), 32'd0);
      checkOutput("junk no mem_we", 32'(weCount - w0), 32'd0);
      busRead(19'h12345, rd);
      checkOutput("junk readback", 32'(rd), 32'(refMem[19'h12345]));
      imageCheck("image after prog");

      // Sector erase of a random inner sector
      sec  = 3'($urandom_range(1, 6));
      base = {sec, 16'h0000};
      unlock();
      applyStimulus({rndHi(), 11'h555}, 8'h80);
      unlock();
      w0 = weCount; a0 = ascErr;
      applyStimulus({sec, 16'($urandom_range(0, 65535))}, 8'h30);
      checkOutput("erase busy", 32'(busy), 32'd1);
      busRead(19'h00000, rd);
      checkOutput("erase status", 32'(rd), 32'h00);
      waitIdle(70000, "erase done");
      checkOutput("erase write count", 32'(weCount - w0), 32'd65536);
      checkOutput("erase ascending", 32'(ascErr - a0), 32'd0);
      checkOutput("erase first addr", 32'(firstWeA), 32'(base));
      checkOutput("below sector", 32'(mem[base - 19'd1]), 32'(refMem[base - 19'd1]));
      checkOutput("above sector", 32'(mem[base + 19'h10000]), 32'(refMem[base + 19'h10000]));
      for (int i = 0; i < 65536; i++) refMem[int'(base) + i] = 8'hFF;
      imageCheck("image after erase");

      // Chip erase aborted by reset
      unlock();
      applyStimulus({rndHi(), 11'h555}, 8'h80);
      unlock();
      w0 = weCount;
      applyStimulus({rndHi(), 11'h555}, 8'h10);
      checkOutput("chip busy", 32'(busy), 32'd1);
      repeat (1000) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("abort busy", 32'(busy), 32'd0);
      checkOutput("abort mem_we", 32'(mem_we), 32'd0);
      n = weCount - w0;
      checkOutput("abort write count", 32'(n >= 990 && n <= 1010), 32'd1);
      nbad = 0;
      for (int i = 0; i < n; i++) if (mem[i] !== 8'hFF) nbad++;
      checkOutput("abort erased bytes", 32'(nbad), 32'd0);
      for (int i = 0; i < n; i++) refMem[i] = 8'hFF;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("after abort writes", 32'(weCount - w0), 32'(n));
      checkOutput("after abort busy", 32'(busy), 32'd0);
      imageCheck("image after abort");
      busRead(19'(n + 5), rd);
      checkOutput("read after abort", 32'(rd), 32'(refMem[n + 5]));

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/flash_resp.md
FLASH_RESP -- requirements
Module: flash_resp

Interface
REQ-001 SHALL have parameter MFR_ID, default 8'h01, autoselect manufacturer code.
REQ-002 SHALL have parameter DEV_ID, default 8'hA4, autoselect device code.
REQ-003 SHALL have parameter PROG_CYCLES, default 16, extra busy clocks after program write (>=1).
REQ-004 clk  in  1  single clock, all logic on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 rom_a  in  19  byte address from flash bus initiator.
REQ-007 rom_d  inout  8  flash data bus; driven only on reads, else Z.
REQ-008 rom_cs_n, rom_oe_n, rom_we_n  in  1 each  active-low chip select, output enable, write enable.
REQ-009 mem_a  out  19  backing-store address.
REQ-010 mem_wd  out  8  backing-store write data.
REQ-011 mem_we  out  1  backing-store write strobe, one byte per asserted clock.
REQ-012 mem_rd  in  8  backing-store read data, valid one clock after mem_a.
REQ-013 busy  out  1  high during embedded program/erase.

Function
REQ-014 SHALL register cs_n/oe_n/we_n once; write cycle = registered cs_n=0 and we_n=0; rom_a/rom_d latched every clock of a write cycle; command committed on the clock registered (cs_n|we_n) rises.
REQ-015 SHALL drive rom_d combinationally when raw rom_cs_n=0, rom_oe_n=0, rom_we_n=1; read data valid <=3 clocks after address/strobes stable.
REQ-016 Command address match SHALL use rom_a[10:0] only (555h, 2AAh).
REQ-017 States: READ, UNL1, UNL2, PGM, ER1, ER2, ER3, ERSEL, AUTOSEL, PROG, ERASE.
REQ-018 READ: AAh@555 -> UNL1; F0h any address -> READ; other writes ignored.
REQ-019 UNL1: 55h@2AA -> UNL2; else -> READ.
REQ-020 UNL2: A0h@555 -> PGM; 80h@555 -> ER1; 90h@555 -> AUTOSEL; else -> READ.
REQ-021 ER1: AAh@555 -> ER2; ER2: 55h@2AA -> ERSEL; ERSEL: 30h any address -> ERASE sector rom_a[18:16]; 10h@555 -> ERASE whole chip; any mismatch -> READ.
REQ-022 PGM: next write -> PROG with latched address A and data D.
REQ-023 PROG: read mem[A] (1-clock latency), write mem[A] <= old & D (bits only clear), then PROG_CYCLES clocks, then READ.
REQ-024 ERASE: write FFh one byte per clock ascending from sector base (64 KiB) or 0 (512 KiB), then READ; sector erase = 65536 write clocks, chip = 524288.
REQ-025 busy SHALL be 1 exactly in PROG/ERASE; bus writes while busy SHALL be ignored (F0h included).
REQ-026 Reads in READ: rom_d = mem[rom_a]; mem_a follows registered rom_a.
REQ-027 Reads in AUTOSEL: rom_a[1:0]=0 -> MFR_ID, 1 -> DEV_ID, else 00h; F0h write -> READ; AA/55 unlock sequence permitted from AUTOSEL as from READ.
REQ-028 Reads while busy: status byte {DQ7, DQ6, 6'b0}; DQ7 = ~D[7] in PROG, 0 in ERASE; DQ6 toggles on every completed read (registered oe_n rising with cs_n low); DQ6 = 0 on entry to busy.
REQ-029 mem_we SHALL be 0 outside PROG write clock and ERASE; mem_wd undefined when mem_we=0.
REQ-030 Unlock/command states (UNL1..ERSEL, PGM) SHALL NOT time out; reads in them return array data.

Reset
REQ-031 rst_n low: state READ, busy 0, mem_we 0, DQ6 0, rom_d Z, mem_a 0.
REQ-032 Reset mid-PROG/ERASE SHALL abort immediately; partially erased/programmed contents remain, no further writes.

Verification
REQ-033 mem preload 5Ah@12345h; read 12345h -> rom_d 5Ah; no mem_we.
REQ-034 AA@555, 55@2AA, A0@555, 0Fh@12345h -> busy 1; two reads give DQ6 0->1->0 pattern toggling, DQ7=1; after completion read 12345h -> 0Ah.
REQ-035 AA,55,80,AA,55 then 30h@20000h -> exactly 65536 mem_we clocks, addresses 20000h..2FFFFh, data FFh; 1FFFFh/30000h untouched.
REQ-036 AA,55,90 then read 0 -> 01h, read 1 -> A4h; F0h -> read 0 returns array data.
REQ-037 AA@555 then 56h@2AA -> state READ; subsequent A0h@555 ignored; no mem_we.
REQ-038 chip erase, rst_n low at clock 1000 -> busy 0, mem_we 0 asynchronously; bytes 0..~998 FFh, rest preserved.
